// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive engine with mid-bit sampling and start-bit glitch rejection.
// Optional even parity (8E1) when UART_RX_PARITY_EN is defined.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_Frame_Err,
    output logic       o_Parity_Err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CW-1:0] HALF_C = CW'(HALF);
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        CLEANUP
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
`ifdef UART_RX_PARITY_EN
    logic          parity_acc;
    logic          parity_bad;
    logic          parity_err_r;
    assign o_Parity_Err = parity_err_r;
`else
    assign o_Parity_Err = 1'b0;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            o_RX_Byte    <= 8'h00;
            o_RX_DV      <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_RX_Active  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_acc   <= 1'b0;
            parity_bad   <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            o_RX_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) begin
                        state       <= START;
                        o_RX_Active <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_acc  <= 1'b0;
                        parity_bad  <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (cnt == HALF_C) begin
                        cnt <= '0;
                        // Line back high at mid-start means a glitch, not a frame.
                        if (rx_s) begin
                            state       <= IDLE;
                            o_RX_Active <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST_C) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
`ifdef UART_RX_PARITY_EN
                        parity_acc     <= parity_acc ^ rx_s;
`endif
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == LAST_C) begin
                        cnt        <= '0;
                        parity_bad <= parity_acc ^ rx_s;
                        state      <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == LAST_C) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state       <= IDLE;
                            o_RX_Active <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (parity_bad) begin
                                parity_err_r <= 1'b1;
                            end else begin
                                o_RX_DV   <= 1'b1;
                                o_RX_Byte <= shift;
                            end
`else
                            o_RX_DV   <= 1'b1;
                            o_RX_Byte <= shift;
`endif
                        end else begin
                            o_Frame_Err <= 1'b1;
                            state       <= CLEANUP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLEANUP: begin
                    // Wait out a break so a held-low line never starts a frame.
                    if (rx_s) begin
                        state       <= IDLE;
                        o_RX_Active <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    o_RX_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver.
module tb_uart_receiver;

    localparam int CPB = 217;
    localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_NOM = 2 + (HALF + 1) + 10 * CPB + 1;
`else
    localparam int LAT_NOM = 2 + (HALF + 1) + 9 * CPB + 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line = 1'b1;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       rx_active;
    logic       frame_err;
    logic       parity_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int dv_lat = 0;
    logic [7:0] byte_log [16];
    int dv_exp = 0;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_RX_Serial (rx_line),
        .o_RX_DV     (rx_dv),
        .o_RX_Byte   (rx_byte),
        .o_RX_Active (rx_active),
        .o_Frame_Err (frame_err),
        .o_Parity_Err(parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Counts cycles each pulse is high, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (rx_dv) begin
            byte_log[dv_cnt[3:0]] = rx_byte;
            dv_lat = cyc - t0;
            dv_cnt = dv_cnt + 1;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (parity_err) pe_cnt = pe_cnt + 1;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        rx_line = 1'b0;
        t0 = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx_line = par_bit;
        repeat (CPB) @(negedge clk);
`else
        if (par_bit) rx_line = rx_line;
`endif
        rx_line = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

    initial begin
        repeat (5) @(negedge clk);
        check_val("rst_byte", rx_byte, 8'h00);
        check_val("rst_outs", {rx_dv, rx_active, frame_err, parity_err}, 0);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        // single good frame
        send_frame(8'h3F, 1'b1, even_par(8'h3F));
        rx_line = 1'b1;
        repeat (CPB) @(negedge clk);
        dv_exp = dv_exp + 1;
        check_val("dv_3f", dv_cnt, dv_exp);
        check_val("byte_3f", rx_byte, 8'h3F);
        check_val("err_3f", fe_cnt + pe_cnt, 0);
        check_val("active_3f", rx_active, 0);
        check_val("lat_3f", (dv_lat >= LAT_NOM - 1 && dv_lat <= LAT_NOM + 1) ? 1 : 0, 1);

        // start-bit glitch
        rx_line = 1'b0;
        repeat (50) @(negedge clk);
        check_val("glitch_active", rx_active, 1);
        rx_line = 1'b1;
        repeat (80) @(negedge clk);
        check_val("glitch_idle", rx_active, 0);
        check_val("glitch_dv", dv_cnt, dv_exp);
        check_val("glitch_err", fe_cnt + pe_cnt, 0);
        repeat (CPB) @(negedge clk);

        // framing error followed by a break, then a good frame
        send_frame(8'hA5, 1'b0, even_par(8'hA5));
        repeat (1500) @(negedge clk);
        check_val("brk_active", rx_active, 1);
        repeat (1500) @(negedge clk);
        check_val("fe_once", fe_cnt, 1);
        check_val("fe_byte", rx_byte, 8'h3F);
        check_val("fe_dv", dv_cnt, dv_exp);
        rx_line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_frame(8'h3C, 1'b1, even_par(8'h3C));
        rx_line = 1'b1;
        repeat (CPB) @(negedge clk);
        dv_exp = dv_exp + 1;
        check_val("dv_3c", dv_cnt, dv_exp);
        check_val("byte_3c", rx_byte, 8'h3C);
        check_val("fe_after", fe_cnt, 1);

        // back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1, even_par(8'h00));
        send_frame(8'hFF, 1'b1, even_par(8'hFF));
        rx_line = 1'b1;
        repeat (CPB) @(negedge clk);
        dv_exp = dv_exp + 2;
        check_val("b2b_dv", dv_cnt, dv_exp);
        check_val("b2b_first", byte_log[2], 8'h00);
        check_val("b2b_second", byte_log[3], 8'hFF);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h3F, 1'b1, 1'b0);
        rx_line = 1'b1;
        repeat (CPB) @(negedge clk);
        dv_exp = dv_exp + 1;
        check_val("par_ok_dv", dv_cnt, dv_exp);
        check_val("par_ok_byte", rx_byte, 8'h3F);
        send_frame(8'h3F, 1'b1, 1'b1);
        rx_line = 1'b1;
        repeat (CPB) @(negedge clk);
        check_val("par_bad_pe", pe_cnt, 1);
        check_val("par_bad_dv", dv_cnt, dv_exp);
        check_val("par_bad_byte", rx_byte, 8'h3F);
`endif

        // reset during data bit 4 of 8'h55
        rx_line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_line = i[0] ? 1'b0 : 1'b1;
            repeat (CPB) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        check_val("pre_rst_active", rx_active, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("mid_rst_byte", rx_byte, 8'h00);
        check_val("mid_rst_outs", {rx_dv, rx_active, frame_err, parity_err}, 0);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        check_val("abort_dv", dv_cnt, dv_exp);
        send_frame(8'h81, 1'b1, even_par(8'h81));
        rx_line = 1'b1;
        repeat (CPB) @(negedge clk);
        dv_exp = dv_exp + 1;
        check_val("dv_81", dv_cnt, dv_exp);
        check_val("byte_81", rx_byte, 8'h81);
        check_val("end_active", rx_active, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
